// File: rtl/fifo_rr_read_arbiter.sv
// fifo_rr_read_arbiter: round-robin burst scheduler draining CH pre-read FIFOs into one registered stream.
// Build option FIFO_ARB_HIPRI_EN: channel 0 becomes strict high priority over a round-robin of 1..CH-1.
`timescale 1ns/1ps
module fifo_rr_read_arbiter #(
  parameter int CH        = 4,
  parameter int DWIDTH    = 8,
  parameter int BURST_LEN = 8,
  parameter int CWIDTH    = 4,
  parameter int U_DLY     = 1
) (
  input  logic                  i_clk_sys,
  input  logic                  i_rst_n,
  input  logic [CH-1:0]         i_empty,
  input  logic [CH*DWIDTH-1:0]  i_rdata,
  input  logic [CH-1:0]         i_ch_en,
  output logic [CH-1:0]         o_ren,
  output logic                  o_valid,
  output logic [DWIDTH-1:0]     o_data,
  output logic [$clog2(CH)-1:0] o_chan,
  output logic                  o_sop,
  input  logic                  i_ready,
  output logic [CH-1:0]         o_grant,
  output logic                  o_busy
);

  localparam int CHW = $clog2(CH);

  typedef enum logic {IDLE, BURST} state_t;

  if (CH < 2 || BURST_LEN < 1 || U_DLY < 0 ||
      BURST_LEN - 1 >= (1 << CWIDTH)) begin : g_bad_cfg
    $error("fifo_rr_read_arbiter: bad parameters");
  end

  state_t            state_q, state_d;
  logic [CHW-1:0]    gnt_q, gnt_d;
  logic [CHW-1:0]    ptr_q, ptr_d;
  logic [CHW-1:0]    pick, idx;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  logic [CH-1:0]     req;
  logic              pick_vld;
  logic              req_g;
  logic              take;
  logic              last;
  logic [DWIDTH-1:0] rdata_g;

  assign req     = ~i_empty & i_ch_en;
  assign req_g   = req[gnt_q];
  assign rdata_g = i_rdata[gnt_q*DWIDTH +: DWIDTH];

  assign take = (state_q == BURST) & req_g &
                (~o_valid | i_ready);
  assign last = take &
                (cnt_q == CWIDTH'(BURST_LEN - 1));

  // Pop strobe is masked by reset so a mid-burst reset never pops.
  assign o_ren   = (take & i_rst_n) ?
                   (CH'(1) << gnt_q) : '0;
  assign o_grant = (state_q == BURST) ?
                   (CH'(1) << gnt_q) : '0;
  assign o_busy  = (state_q == BURST);

  // Next grant: nearest requester after ptr_q; scanning far-to-near
  // lets the nearest one overwrite the others.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = CH; i >= 1; i--) begin
      idx = CHW'((int'(ptr_q) + i) % CH);
`ifdef FIFO_ARB_HIPRI_EN
      if (idx != '0 && req[idx]) begin
`else
      if (req[idx]) begin
`endif
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
`ifdef FIFO_ARB_HIPRI_EN
    if (req[0]) begin
      pick     = '0;
      pick_vld = 1'b1;
    end
`endif
  end

  // Grant FSM: latch a winner in IDLE, stream from it in BURST.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BURST;
          gnt_d   = pick;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (take) begin
          cnt_d = cnt_q + CWIDTH'(1);
        end
        if (last || !req_g) begin
          state_d = IDLE;
`ifdef FIFO_ARB_HIPRI_EN
          if (gnt_q != '0) begin
            ptr_d = gnt_q;
          end
`else
          ptr_d = gnt_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, grant, burst count and round-robin pointer.
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= CHW'(CH - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Output word register: load on pop, drop valid once accepted.
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_chan  <= '0;
      o_sop   <= 1'b0;
    end else if (take) begin
      o_valid <= 1'b1;
      o_data  <= rdata_g;
      o_chan  <= gnt_q;
      o_sop   <= (cnt_q == '0);
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rr_read_arbiter.sv
// tb_fifo_rr_read_arbiter: FIFO channel models, burst-level reference model
// and scenario tasks for fifo_rr_read_arbiter (CH=4, BURST_LEN=4).
`timescale 1ns/1ps
module tb_fifo_rr_read_arbiter;

  localparam int CH = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] empty = '1;
  logic [CH*DW-1:0] rdata = '0;
  logic [CH-1:0] en = '1;
  logic [CH-1:0] ren;
  logic          valid;
  logic [DW-1:0] data;
  logic [1:0]    chan;
  logic          sop;
  logic          ready = 1'b1;
  logic [CH-1:0] grant;
  logic          busy;

  logic [7:0]  fq [CH][$];
  logic [7:0]  ld [CH][$];
  logic [10:0] got [$];
  logic [10:0] exp_q [$];
  int          pop_cyc [$];
  int          glog [$];
  int          pops [CH];
  int          cyc = 0;
  int          gi;
  logic [CH-1:0] pend = '0;
  logic        pv = 1'b0, pr = 1'b0, ps = 1'b0;
  logic        prst = 1'b0, pbusy = 1'b0;
  logic [7:0]  pd = '0;
  logic [1:0]  pc = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  fifo_rr_read_arbiter #(
    .CH(CH), .DWIDTH(DW), .BURST_LEN(BL),
    .CWIDTH(4), .U_DLY(1)
  ) dut (
    .i_clk_sys(clk),
    .i_rst_n(rst_n),
    .i_empty(empty),
    .i_rdata(rdata),
    .i_ch_en(en),
    .o_ren(ren),
    .o_valid(valid),
    .o_data(data),
    .o_chan(chan),
    .o_sop(sop),
    .i_ready(ready),
    .o_grant(grant),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  // Pre-read FIFO models: pop what was strobed, then present new head.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < CH; k++) begin
      if (pend[k] && fq[k].size() > 0) begin
        void'(fq[k].pop_front());
        pops[k]++;
      end
    end
    for (int k = 0; k < CH; k++) begin
      empty[k] = (fq[k].size() == 0);
      rdata[k*DW +: DW] = (fq[k].size() > 0) ? fq[k][0] : 8'h00;
    end
  end

  // Mid-cycle monitor: legality, output hold, accepted words, grants.
  always @(negedge clk) begin
    cyc++;
    pend = ren;
    if (rst_n) begin
      n_cmp++;
      if ((ren & ~(~empty & en)) !== '0 || !$onehot0(ren)) begin
        n_bad++;
        $display("FAIL ren_legal: ren=%b empty=%b en=%b", ren, empty, en);
      end
      if (pv && !pr && prst) begin
        n_cmp++;
        if (valid !== 1'b1 || data !== pd || chan !== pc || sop !== ps) begin
          n_bad++;
          $display("FAIL hold: got v%b %h c%0d s%b want v1 %h c%0d s%b",
                   valid, data, chan, sop, pd, pc, ps);
        end
      end
      if (ren != '0) pop_cyc.push_back(cyc);
      if (valid && ready) got.push_back({sop, chan, data});
      if (busy && !pbusy) begin
        gi = 0;
        for (int k = 0; k < CH; k++) if (grant[k]) gi = k;
        glog.push_back(gi);
      end
    end
    pv = valid; pr = ready; pd = data; pc = chan; ps = sop;
    prst = rst_n; pbusy = busy;
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    ready = 1'b1;
    en = '1;
    for (int k = 0; k < CH; k++) begin
      fq[k].delete();
      ld[k].delete();
      pops[k] = 0;
    end
    got.delete(); pop_cyc.delete();
    glog.delete(); exp_q.delete();
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic load(input int k, input logic [7:0] d);
    fq[k].push_back(d);
    ld[k].push_back(d);
  endtask

  // Burst-level model of static FIFO contents under mask m.
  task automatic build_model(input logic [CH-1:0] m);
    int cnt [CH];
    int rd [CH];
    int ptr, c, n;
    bit done, hp;
    hp = 1'b0;
`ifdef FIFO_ARB_HIPRI_EN
    hp = 1'b1;
`endif
    exp_q.delete();
    ptr = CH - 1;
    done = 1'b0;
    for (int k = 0; k < CH; k++) begin
      cnt[k] = ld[k].size();
      rd[k] = 0;
    end
    while (!done) begin
      c = -1;
      if (hp && m[0] && cnt[0] > 0) c = 0;
      for (int i = 1; i <= CH; i++) begin
        int idx = (ptr + i) % CH;
        if (c < 0 && m[idx] && cnt[idx] > 0 && (!hp || idx != 0)) c = idx;
      end
      if (c < 0) begin
        done = 1'b1;
      end else begin
        n = (cnt[c] < BL) ? cnt[c] : BL;
        for (int j = 0; j < n; j++)
          exp_q.push_back({(j == 0), 2'(c), ld[c][rd[c] + j]});
        rd[c] += n;
        cnt[c] -= n;
        if (!(hp && c == 0)) ptr = c;
      end
    end
  endtask

  task automatic run_until(input int n, input int budget,
                           input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (got.size() >= n && !busy && !valid) begin
        ok = 1'b1;
        break;
      end
      if (rnd) ready = ($urandom_range(0, 3) != 0);
    end
    ready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0 || sop !== 1'b0 || data !== 8'h00 || chan !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_out: v%b s%b d%h c%0d want all 0", valid, sop, data, chan);
    end
    n_cmp++;
    if (ren !== '0 || grant !== '0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: ren=%b grant=%b busy=%b want 0", ren, grant, busy);
    end
  endtask

  task automatic test_single_channel();
    bit ok;
    do_reset();
    load(2, 8'h21); load(2, 8'h22); load(2, 8'h23);
    build_model('1);
    run_until(3, 100, 1'b0, ok);
    n_cmp++;
    if (!ok || got.size() != 3) begin
      n_bad++;
      $display("FAIL single_len: got %0d words ok=%b want 3", got.size(), ok);
    end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL single[%0d]: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (pop_cyc.size() != 3 || pop_cyc[2] - pop_cyc[0] != 2 || pops[2] != 3) begin
      n_bad++;
      $display("FAIL single_ren: pops=%0d ren cycles=%0d want 3 consecutive",
               pops[2], pop_cyc.size());
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int blen, eg;
    do_reset();
    for (int k = 0; k < CH; k++)
      for (int w = 0; w < 10; w++) load(k, 8'(k * 16 + w));
    build_model('1);
    run_until(40, 500, 1'b0, ok);
    repeat (5) @(posedge clk);
    #2;
    n_cmp++;
    if (!ok || got.size() != 40) begin
      n_bad++;
      $display("FAIL rr_len: got %0d words ok=%b want 40", got.size(), ok);
    end
    for (int i = 0; i < got.size() && i < 40; i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL rr_word[%0d]: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (glog.size() <= i || glog[i] != i % CH) begin
        n_bad++;
        $display("FAIL rr_grant[%0d]: got %0d want %0d", i,
                 (glog.size() > i) ? glog[i] : -1, i % CH);
      end
    end
    n_cmp++;
    if (pop_cyc.size() != 40) begin
      n_bad++;
      $display("FAIL rr_pops: got %0d want 40", pop_cyc.size());
    end else begin
      blen = 1;
      for (int i = 1; i < 40; i++) begin
        if (exp_q[i][10]) begin
          eg = (blen == BL) ? 2 : 3;
          blen = 1;
        end else begin
          eg = 1;
          blen++;
        end
        n_cmp++;
        if (pop_cyc[i] - pop_cyc[i-1] != eg) begin
          n_bad++;
          $display("FAIL rr_gap[%0d]: got %0d want %0d", i,
                   pop_cyc[i] - pop_cyc[i-1], eg);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    for (int w = 0; w < 6; w++) load(1, 8'(8'h10 + w));
    build_model('1);
    for (int i = 0; i < 50 && got.size() < 2; i++) begin
      @(posedge clk); #2;
    end
    ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      n_cmp++;
      if (ren !== '0 || valid !== 1'b1 || data !== exp_q[2][7:0]) begin
        n_bad++;
        $display("FAIL bp_stall[%0d]: ren=%b v=%b d=%h want 0 1 %h",
                 j, ren, valid, data, exp_q[2][7:0]);
      end
    end
    @(posedge clk); #2;
    ready = 1'b1;
    run_until(6, 100, 1'b0, ok);
    n_cmp++;
    if (!ok || got.size() != 6) begin
      n_bad++;
      $display("FAIL bp_len: got %0d ok=%b want 6", got.size(), ok);
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL bp_word[%0d]: got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ch_enable();
    bit ok;
    do_reset();
    for (int w = 0; w < 6; w++) load(1, 8'(8'hA0 + w));
    for (int w = 0; w < 3; w++) load(2, 8'(8'hB0 + w));
    exp_q.delete();
    exp_q.push_back({1'b1, 2'd1, 8'hA0});
    exp_q.push_back({1'b0, 2'd1, 8'hA1});
    exp_q.push_back({1'b1, 2'd2, 8'hB0});
    exp_q.push_back({1'b0, 2'd2, 8'hB1});
    exp_q.push_back({1'b0, 2'd2, 8'hB2});
    exp_q.push_back({1'b1, 2'd1, 8'hA2});
    exp_q.push_back({1'b0, 2'd1, 8'hA3});
    exp_q.push_back({1'b0, 2'd1, 8'hA4});
    exp_q.push_back({1'b0, 2'd1, 8'hA5});
    for (int i = 0; i < 50 && pops[1] < 2; i++) begin
      @(posedge clk); #2;
    end
    en = 4'b1101;
    run_until(5, 100, 1'b0, ok);
    repeat (10) @(posedge clk);
    #2;
    n_cmp++;
    if (!ok || glog.size() != 2 || glog[1] != 2 || pops[1] != 2) begin
      n_bad++;
      $display("FAIL en_skip: ok=%b grants=%0d pops1=%0d want 2 grants, 2nd ch2, 2 pops",
               ok, glog.size(), pops[1]);
    end
    en = 4'b1111;
    run_until(9, 100, 1'b0, ok);
    n_cmp++;
    if (!ok || got.size() != 9 || glog.size() != 3 || glog[2] != 1) begin
      n_bad++;
      $display("FAIL en_resume: ok=%b words=%0d grants=%0d want 9 words, 3rd grant ch1",
               ok, got.size(), glog.size());
    end
    for (int i = 0; i < got.size() && i < 9; i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL en_word[%0d]: got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int w = 0; w < 6; w++) load(1, 8'(8'h30 + w));
    for (int w = 0; w < 8; w++) load(2, 8'(8'h40 + w));
    for (int w = 0; w < 4; w++) load(3, 8'(8'h50 + w));
    for (int i = 0; i < 60 && pops[2] < 2; i++) begin
      @(posedge clk); #2;
    end
    rst_n = 1'b0;
    glog.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0 || ren !== '0 || busy !== 1'b0 || pops[2] != 2) begin
      n_bad++;
      $display("FAIL mid_rst: v=%b ren=%b busy=%b pops2=%0d want 0 0 0 2",
               valid, ren, busy, pops[2]);
    end
    for (int i = 0; i < 20 && glog.size() == 0; i++) @(negedge clk);
    n_cmp++;
    if (glog.size() == 0 || glog[0] != 1) begin
      n_bad++;
      $display("FAIL mid_rst_grant: got %0d want 1",
               (glog.size() > 0) ? glog[0] : -1);
    end
  endtask

  task automatic test_priority();
    int want [4];
`ifdef FIFO_ARB_HIPRI_EN
    want = '{0, 0, 0, 0};
`else
    want = '{0, 3, 0, 3};
`endif
    do_reset();
    for (int w = 0; w < 16; w++) begin
      load(0, 8'(w));
      load(3, 8'(8'h80 + w));
    end
    for (int i = 0; i < 100 && glog.size() < 4; i++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (glog.size() <= i || glog[i] != want[i]) begin
        n_bad++;
        $display("FAIL prio_grant[%0d]: got %0d want %0d", i,
                 (glog.size() > i) ? glog[i] : -1, want[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [CH-1:0] m;
    int nw;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      m = 4'($urandom_range(1, 15));
      en = m;
      for (int k = 0; k < CH; k++) begin
        nw = $urandom_range(0, 9);
        for (int w = 0; w < nw; w++) load(k, 8'($urandom));
      end
      build_model(m);
      run_until(exp_q.size(), 1500, 1'b1, ok);
      n_cmp++;
      if (!ok || got.size() != exp_q.size()) begin
        n_bad++;
        $display("FAIL rnd%0d_len: got %0d ok=%b want %0d",
                 it, got.size(), ok, exp_q.size());
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (got[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL rnd%0d_word[%0d]: got %h want %h",
                   it, i, got[i], exp_q[i]);
        end
      end
      for (int k = 0; k < CH; k++) begin
        if (!m[k]) begin
          n_cmp++;
          if (fq[k].size() != ld[k].size()) begin
            n_bad++;
            $display("FAIL rnd%0d_off%0d: left %0d want %0d",
                     it, k, fq[k].size(), ld[k].size());
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_backpressure();
    test_ch_enable();
    test_reset_mid_burst();
    test_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
